swerv_axi_rd_arb: RTL
=====================

SWERV_AXI_RD_ARB -- requirements
Module: swerv_axi_rd_arb

Interface
REQ-001 Parameter ID_W, default 3: master AXI ID width (IFU/LSU bus tag).
REQ-002 Parameter DW, default 64: read data width.
REQ-003 clk  in  1  core clock; the single clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 m0_arvalid, m1_arvalid  in  1  read-address request; m0 is IFU, m1 is LSU.
REQ-006 m0_arready, m1_arready  out  1  address accepted.
REQ-007 m0_/m1_ arid, araddr, arlen, arsize, arburst  in  ID_W/32/8/3/2  address payload.
REQ-008 m0_rvalid, m1_rvalid  out  1  read beat valid.
REQ-009 m0_rready, m1_rready  in  1  master accepts beat.
REQ-010 m0_/m1_ rid, rdata, rresp, rlast  out  ID_W/DW/2/1  routed beat payload.
REQ-011 s_arvalid/s_arready  out/in  1  slave address handshake.
REQ-012 s_arid, s_araddr, s_arlen, s_arsize, s_arburst  out  ID_W+1/32/8/3/2  slave payload.
REQ-013 s_rvalid/s_rready  in/out  1  slave beat handshake.
REQ-014 s_rid, s_rdata, s_rresp, s_rlast  in  ID_W+1/DW/2/1  slave beat payload.
REQ-015 prot_err  out  1  sticky protocol-error flag.

Function
REQ-016 FSM states: IDLE, ADDR, DATA.
REQ-017 IDLE: any m*_arvalid -> register grant, latch payload, go to ADDR next cycle.
REQ-018 Arbitration round-robin: when both request, grant the master not granted last; after reset, m0 wins the first tie.
REQ-019 ADDR: s_arvalid=1 with latched payload; s_arid = {grant, latched arid}; payload stable until s_arready.
REQ-020 Granted m*_arready is pulsed for exactly the cycle the payload is latched in IDLE; non-granted arready stays 0.
REQ-021 ADDR & s_arready -> DATA; beat counter loaded with latched arlen.
REQ-022 DATA: s_rvalid/s_rdata/s_rresp/s_rlast/s_rid[ID_W-1:0] pass combinationally to the granted master; s_rready = granted m*_rready; non-granted rvalid = 0.
REQ-023 Each accepted beat (s_rvalid & s_rready) decrements the counter.
REQ-024 Beat accepted with s_rlast=1 -> IDLE; new grant no earlier than the following cycle.
REQ-025 One outstanding transaction in total; no address is accepted from either master outside IDLE.
REQ-026 s_rlast=1 with counter != 0, or counter == 0 with s_rlast=0 -> prot_err set; the FSM still follows s_rlast.
REQ-027 s_rid MSB != grant on an accepted beat -> prot_err set; the beat is still routed to the granted master.
REQ-028 arlen=255 (256 beats) is supported; the counter is 8 bits with no wrap before rlast.
REQ-029 A master deasserting arvalid before grant is legal; arbitration uses current-cycle arvalid only.

Reset
REQ-030 rst -> state IDLE, last-grant = m1 (so m0 wins the first tie), counter 0, prot_err 0, all valid/ready outputs 0.
REQ-031 rst mid-transaction -> abandon the burst in one cycle; no beats are routed after the reset cycle.

Structure
REQ-032 The FSM state enum and the grant-index typedef live in the shared swerv_types package.
REQ-033 Round-robin grant logic is one sub-module: swerv_rr_arb2 (req[1:0], last, gnt[1:0]).

Verification
REQ-034 Only m0 requests, arid=5, arlen=3; slave returns 4 beats -> s_arid=4'b0101; m0 gets 4 beats, rlast on the 4th; state back to IDLE.
REQ-035 m0 and m1 request together, three back-to-back times -> grants m0, m1, m0.
REQ-036 m1 burst arlen=0 with m1_rready low for 5 cycles -> s_rready low for 5 cycles; beat delivered when m1_rready rises; m0_rvalid never 1.
REQ-037 arlen=1; slave asserts rlast on beat 1 -> prot_err=1 and stays 1; FSM returns to IDLE.
REQ-038 rst asserted during beat 2 of a 4-beat burst -> next cycle: IDLE, all rvalid 0, prot_err 0.
REQ-039 arlen=255 -> 256 beats routed, no prot_err.

Source files
------------

// File: rtl/swerv_types.sv
// Shared SweRV bus types: read-arbiter FSM states and the master grant index.
// Pure types and constants, so there is no latency and no backpressure.
package swerv_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    // Index 0 is the IFU (m0) and index 1 is the LSU (m1).
    typedef logic gnt_idx_t;

    localparam gnt_idx_t GNT_M0 = 1'b0;
    localparam gnt_idx_t GNT_M1 = 1'b1;

    function automatic gnt_idx_t onehot_to_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/swerv_rr_arb2.sv
// Two-way round-robin arbiter: combinational and zero latency; on a tie it favours the requester not served last.
// Holds no state and has no backpressure; the caller owns the last-grant register.
module swerv_rr_arb2
    import swerv_types::*;
(
    input  logic [1:0] req,
    input  gnt_idx_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/swerv_axi_rd_arb.sv
// Arbitrates the IFU and LSU AXI read channels onto one slave port, one burst at a time; address reaches the slave 1 cycle after grant.
// R beats pass combinationally, so the slave sees the granted master's rready; the other master waits in IDLE-only arbitration.
module swerv_axi_rd_arb
    import swerv_types::*;
#(
    parameter int ID_W = 3,
    parameter int DW   = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_arvalid,
    output logic            m0_arready,
    input  logic [ID_W-1:0] m0_arid,
    input  logic [31:0]     m0_araddr,
    input  logic [7:0]      m0_arlen,
    input  logic [2:0]      m0_arsize,
    input  logic [1:0]      m0_arburst,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    output logic [ID_W-1:0] m0_rid,
    output logic [DW-1:0]   m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rlast,

    input  logic            m1_arvalid,
    output logic            m1_arready,
    input  logic [ID_W-1:0] m1_arid,
    input  logic [31:0]     m1_araddr,
    input  logic [7:0]      m1_arlen,
    input  logic [2:0]      m1_arsize,
    input  logic [1:0]      m1_arburst,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [ID_W-1:0] m1_rid,
    output logic [DW-1:0]   m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rlast,

    output logic            s_arvalid,
    input  logic            s_arready,
    output logic [ID_W:0]   s_arid,
    output logic [31:0]     s_araddr,
    output logic [7:0]      s_arlen,
    output logic [2:0]      s_arsize,
    output logic [1:0]      s_arburst,
    input  logic            s_rvalid,
    output logic            s_rready,
    input  logic [ID_W:0]   s_rid,
    input  logic [DW-1:0]   s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rlast,

    output logic            prot_err
);

    rd_state_e       state_q, state_d;
    gnt_idx_t        grant_q, grant_d;
    logic [ID_W-1:0] arid_q, arid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [7:0]      arlen_q, arlen_d;
    logic [2:0]      arsize_q, arsize_d;
    logic [1:0]      arburst_q, arburst_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            prot_err_q, prot_err_d;

    logic [1:0]      arb_gnt;
    logic            beat;

    // grant_q doubles as the last-grant history once the burst is done.
    swerv_rr_arb2 u_arb (
        .req  ({m1_arvalid, m0_arvalid}),
        .last (grant_q),
        .gnt  (arb_gnt)
    );

    assign s_arid    = {grant_q, arid_q};
    assign s_araddr  = araddr_q;
    assign s_arlen   = arlen_q;
    assign s_arsize  = arsize_q;
    assign s_arburst = arburst_q;

    assign m0_rid   = s_rid[ID_W-1:0];
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rid   = s_rid[ID_W-1:0];
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    assign prot_err = prot_err_q;
    assign beat     = s_rvalid & s_rready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        cnt_d      = cnt_q;
        prot_err_d = prot_err_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    grant_d    = onehot_to_idx(arb_gnt);
                    m0_arready = arb_gnt[0];
                    m1_arready = arb_gnt[1];
                    arid_d     = arb_gnt[1] ? m1_arid    : m0_arid;
                    araddr_d   = arb_gnt[1] ? m1_araddr  : m0_araddr;
                    arlen_d    = arb_gnt[1] ? m1_arlen   : m0_arlen;
                    arsize_d   = arb_gnt[1] ? m1_arsize  : m0_arsize;
                    arburst_d  = arb_gnt[1] ? m1_arburst : m0_arburst;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    cnt_d   = arlen_q;
                    state_d = DATA;
                end
            end
            DATA: begin
                s_rready  = (grant_q == GNT_M1) ? m1_rready : m0_rready;
                m0_rvalid = (grant_q == GNT_M0) & s_rvalid;
                m1_rvalid = (grant_q == GNT_M1) & s_rvalid;
                if (beat) begin
                    // Beat count and rlast must agree; the slave's rlast still ends the burst.
                    if (s_rlast != (cnt_q == 8'd0)) prot_err_d = 1'b1;
                    if (s_rid[ID_W] != grant_q)     prot_err_d = 1'b1;
                    if (cnt_q != 8'd0)              cnt_d      = cnt_q - 8'd1;
                    if (s_rlast)                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            m0_arready = 1'b0;
            m1_arready = 1'b0;
            s_arvalid  = 1'b0;
            s_rready   = 1'b0;
            m0_rvalid  = 1'b0;
            m1_rvalid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GNT_M1;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            cnt_q      <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            cnt_q      <= cnt_d;
            prot_err_q <= prot_err_d;
        end
    end

endmodule
